lsu_sequencer: RTL and testbench
================================

Name: lsu_sequencer

Overview:
- Multi-cycle load/store sequencer between the main decoder's memory controls and a req/ack data-memory bus (RV64, 64-bit data).
- Per memory instruction it stalls the pipeline, issues one aligned bus transaction with byte enables, and extracts and extends load data.
- It flags misaligned accesses without touching the bus.

Parameters:
- XLEN, 64, register/data width; fixed at 64 (bus is 8 bytes wide).
- TIMEOUT_CYCLES, 255, max REQ cycles without ack (used only with LSU_TIMEOUT_EN).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- memRead  in  2  [0]=load, [1]=unsigned load
- memWrite  in  1  store
- memMask  in  3  000 byte, 001 half, 010 word, 011 double; others treated as double
- addr  in  64  effective byte address
- wdata  in  64  store data, LSB-aligned
- stall  out  1  hold pipeline
- done  out  1  one-cycle completion pulse
- fault  out  1  misaligned (or timeout) on this completion
- rdata  out  64  extended load result, valid while done=1
- bus_req  out  1  transaction request
- bus_we  out  1  1=write
- bus_addr  out  64  {addr[63:3],3'b000}
- bus_be  out  8  byte enables
- bus_wdata  out  64  store data shifted to lane
- bus_ack  in  1  transaction complete (read data valid this cycle)
- bus_rdata  in  64  read data

Behaviour:
- FSM states: IDLE, REQ, DONE. Reset (reset=0, async) -> IDLE; all outputs and internal registers 0; bus_req drops immediately even mid-REQ.
- IDLE: request = memWrite | memRead[0]. If memWrite and memRead[0] are both set, the store wins and the load bit is ignored.
- IDLE on request: register addr, size, unsigned, we, wdata.
  - If aligned -> REQ.
  - If misaligned (half addr[0]!=0; word addr[1:0]!=0; double addr[2:0]!=0) -> DONE with fault latched 1; no bus activity.
- stall (combinational) = (IDLE & request) | REQ. stall=0 in DONE.
- REQ: bus_req=1, bus_we=we, bus_addr aligned, bus_be = size mask (01/03/0F/FF) << addr[2:0], bus_wdata = wdata << 8*addr[2:0]. All are held stable until bus_ack=1 is sampled. On ack -> DONE.
- Loads: rdata register <= (bus_rdata >> 8*addr[2:0]) truncated to size, then sign-extended (unsigned=0) or zero-extended (unsigned=1); double is unchanged. Stores: rdata <= 0.
- DONE: done=1 for exactly one cycle, rdata/fault valid. Inputs are ignored (same instruction still present) -> IDLE. fault and rdata hold until the next DONE.
- Latency: aligned access with ack in the first REQ cycle = stall for 2 cycles, done in the 3rd cycle. Each extra wait cycle adds 1. Misaligned: stall 1 cycle, done in the 2nd.
- bus_ack outside REQ is ignored.
- Back-to-back memory instructions: each starts from IDLE, so there is a minimum 3-cycle spacing.

Optional Feature:
- Macro LSU_TIMEOUT_EN.
- Defined: an 8+ bit counter clears on entry to REQ and increments each REQ cycle without ack. When it reaches TIMEOUT_CYCLES, the FSM drops bus_req, goes to DONE with fault=1, rdata=0. An ack in the same cycle as expiry wins (normal completion).
- Undefined: no counter; REQ waits indefinitely for bus_ack.

Test Plan:
- Load byte signed, addr=0x1003, bus_rdata=0x0000_0000_8000_0000, ack in 1st REQ cycle -> bus_be=0x08, bus_addr=0x1000, stall 2 cycles, done in cycle 3, rdata=0xFFFF_FFFF_FFFF_FF80, fault=0.
- Load half unsigned, addr=0x2006, bus_rdata=0xBEEF_0000_0000_0000, ack after 3 wait cycles -> bus_be=0xC0, stall 5 cycles, rdata=0x0000_0000_0000_BEEF.
- Store word wdata=0x1234_5678, addr=0x3004 -> bus_we=1, bus_be=0xF0, bus_wdata=0x1234_5678_0000_0000, done=1, rdata=0.
- Misaligned double load addr=0x4004 -> bus_req never asserted, stall 1 cycle, done with fault=1, rdata=0.
- reset=0 asserted mid-REQ, then released -> bus_req, stall, done 0 immediately; the FSM restarts from IDLE and the next request sequences normally.
- With LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> bus_req drops after 4 REQ cycles, done with fault=1. Without the macro, bus_req stays high for 100+ cycles.

Source files
------------

// File: rtl/lsu_sequencer.sv
// Load/store sequencer: one aligned req/ack bus transaction per memory instruction, with
// misalignment detection. Optional REQ-phase timeout under `define LSU_TIMEOUT_EN.
module lsu_sequencer #(
  parameter int unsigned XLEN           = 64,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      memRead,
  input  logic            memWrite,
  input  logic [2:0]      memMask,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic            stall,
  output logic            done,
  output logic            fault,
  output logic [XLEN-1:0] rdata,
  output logic            bus_req,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [7:0]      bus_be,
  output logic [XLEN-1:0] bus_wdata,
  input  logic            bus_ack,
  input  logic [XLEN-1:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t          state;
  logic [1:0]      size_r;
  logic            uns_r;
  logic [2:0]      off_r;

  logic            request;
  logic            misaligned;
  logic [1:0]      size_in;
  logic [7:0]      be_base;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] ext;

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] to_cnt;
`endif

  always_comb begin
    request    = memWrite | memRead[0];
    size_in    = memMask[2] ? 2'b11 : memMask[1:0];
    misaligned = 1'b0;
    be_base    = 8'h00;
    case (size_in)
      2'b00: be_base = 8'h01;
      2'b01: begin be_base = 8'h03; misaligned = addr[0];      end
      2'b10: begin be_base = 8'h0F; misaligned = |addr[1:0];   end
      default: begin be_base = 8'hFF; misaligned = |addr[2:0]; end
    endcase
    // Gated by reset so the pipeline is released the moment reset asserts.
    stall = reset && (((state == IDLE) && request) || (state == REQ));
  end

  always_comb begin
    shifted = bus_rdata >> {off_r, 3'b000};
    ext     = shifted;
    case (size_r)
      2'b00: ext = uns_r ? {{(XLEN-8){1'b0}}, shifted[7:0]}
                         : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      2'b01: ext = uns_r ? {{(XLEN-16){1'b0}}, shifted[15:0]}
                         : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      2'b10: ext = uns_r ? {{(XLEN-32){1'b0}}, shifted[31:0]}
                         : {{(XLEN-32){shifted[31]}}, shifted[31:0]};
      default: ext = shifted;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      size_r    <= '0;
      uns_r     <= 1'b0;
      off_r     <= '0;
      done      <= 1'b0;
      fault     <= 1'b0;
      rdata     <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
`ifdef LSU_TIMEOUT_EN
      to_cnt    <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (request) begin
            size_r <= size_in;
            uns_r  <= memRead[1] & ~memWrite;
            off_r  <= addr[2:0];
            if (misaligned) begin
              state <= DONE;
              done  <= 1'b1;
              fault <= 1'b1;
              rdata <= '0;
            end else begin
              state     <= REQ;
              bus_req   <= 1'b1;
              bus_we    <= memWrite;
              bus_addr  <= {addr[XLEN-1:3], 3'b000};
              bus_be    <= be_base << addr[2:0];
              bus_wdata <= memWrite ? (wdata << {addr[2:0], 3'b000}) : '0;
`ifdef LSU_TIMEOUT_EN
              to_cnt    <= '0;
`endif
            end
          end
        end
        REQ: begin
          if (bus_ack) begin
            state   <= DONE;
            done    <= 1'b1;
            fault   <= 1'b0;
            rdata   <= bus_we ? '0 : ext;
            bus_req <= 1'b0;
            bus_we  <= 1'b0;
            bus_be  <= '0;
`ifdef LSU_TIMEOUT_EN
          end else if (to_cnt == TO_LAST) begin
            state   <= DONE;
            done    <= 1'b1;
            fault   <= 1'b1;
            rdata   <= '0;
            bus_req <= 1'b0;
            bus_we  <= 1'b0;
            bus_be  <= '0;
          end else begin
            to_cnt  <= to_cnt + CW'(1);
`endif
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_sequencer.sv
// Directed self-checking bench for lsu_sequencer; define LSU_TIMEOUT_EN to exercise the timeout path.
module tb_lsu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  memRead;
  logic        memWrite;
  logic [2:0]  memMask;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic        stall;
  logic        done;
  logic        fault;
  logic [63:0] rdata;
  logic        bus_req;
  logic        bus_we;
  logic [63:0] bus_addr;
  logic [7:0]  bus_be;
  logic [63:0] bus_wdata;
  logic        bus_ack;
  logic [63:0] bus_rdata;

  always #5 clk = ~clk;

  lsu_sequencer #(.XLEN(64), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .memRead(memRead), .memWrite(memWrite), .memMask(memMask),
    .addr(addr), .wdata(wdata), .stall(stall), .done(done), .fault(fault), .rdata(rdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  int total = 0;
  int bad   = 0;

  int          n_stall, n_req, done_cyc;
  logic        saw_req, held_ok, cap_we, cap_fault, done_after;
  logic [7:0]  cap_be;
  logic [63:0] cap_addr, cap_wdata, cap_rdata;

  task automatic clear_inputs();
    memRead  = 2'b00;
    memWrite = 1'b0;
    memMask  = 3'b000;
    addr     = '0;
    wdata    = '0;
    bus_ack  = 1'b0;
  endtask

  // Drive one instruction, ack on REQ cycle waits+1, record what the bus and outputs showed.
  task automatic do_access(input logic [1:0] rd, input logic wr, input logic [2:0] mk,
                           input logic [63:0] a, input logic [63:0] wd, input int waits,
                           input logic [63:0] rdat);
    n_stall = 0; n_req = 0; done_cyc = 0; saw_req = 1'b0; held_ok = 1'b1;
    cap_we = 1'b0; cap_be = '0; cap_addr = '0; cap_wdata = '0; cap_rdata = '0; cap_fault = 1'b0;
    @(posedge clk); #1;
    memRead = rd; memWrite = wr; memMask = mk; addr = a; wdata = wd;
    bus_rdata = rdat; bus_ack = 1'b0;
    for (int cyc = 1; cyc <= 64 && done_cyc == 0; cyc++) begin
      @(negedge clk);
      if (stall) n_stall++;
      if (bus_req) begin
        n_req++;
        if (!saw_req) begin
          cap_we = bus_we; cap_be = bus_be; cap_addr = bus_addr; cap_wdata = bus_wdata;
        end else if (bus_we !== cap_we || bus_be !== cap_be || bus_addr !== cap_addr ||
                     bus_wdata !== cap_wdata) begin
          held_ok = 1'b0;
        end
        saw_req = 1'b1;
      end
      if (done) begin
        done_cyc = cyc; cap_rdata = rdata; cap_fault = fault;
      end
      bus_ack = bus_req && (n_req == waits + 1);
    end
    bus_ack = 1'b0;
    @(posedge clk); #1;
    clear_inputs();
    @(negedge clk);
    done_after = done;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear_inputs();
    bus_rdata = '0;
    @(negedge clk);
    total++; if ({stall, done, fault, bus_req, bus_we} !== 5'b0) begin bad++;
      $display("FAIL reset_ctrl: got %b want 00000", {stall, done, fault, bus_req, bus_we}); end
    total++; if (rdata !== 64'h0 || bus_addr !== 64'h0 || bus_wdata !== 64'h0 || bus_be !== 8'h0) begin bad++;
      $display("FAIL reset_data: rdata=%h addr=%h wdata=%h be=%h want all 0", rdata, bus_addr, bus_wdata, bus_be); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_load_byte_signed();
    do_access(2'b01, 1'b0, 3'b000, 64'h1003, 64'h0, 0, 64'h0000_0000_8000_0000);
    total++; if (cap_be !== 8'h08) begin bad++; $display("FAIL lb_be: got %h want 08", cap_be); end
    total++; if (cap_addr !== 64'h1000) begin bad++; $display("FAIL lb_addr: got %h want 1000", cap_addr); end
    total++; if (cap_we !== 1'b0) begin bad++; $display("FAIL lb_we: got %b want 0", cap_we); end
    total++; if (n_stall != 2) begin bad++; $display("FAIL lb_stall: got %0d want 2", n_stall); end
    total++; if (done_cyc != 3) begin bad++; $display("FAIL lb_done_cycle: got %0d want 3", done_cyc); end
    total++; if (cap_rdata !== 64'hFFFF_FFFF_FFFF_FF80) begin bad++;
      $display("FAIL lb_rdata: got %h want ffffffffffffff80", cap_rdata); end
    total++; if (cap_fault !== 1'b0) begin bad++; $display("FAIL lb_fault: got %b want 0", cap_fault); end
    total++; if (done_after !== 1'b0) begin bad++; $display("FAIL lb_done_pulse: got %b want 0", done_after); end
  endtask

  task automatic test_load_half_unsigned_wait();
    do_access(2'b11, 1'b0, 3'b001, 64'h2006, 64'h0, 3, 64'hBEEF_0000_0000_0000);
    total++; if (cap_be !== 8'hC0) begin bad++; $display("FAIL lhu_be: got %h want c0", cap_be); end
    total++; if (n_stall != 5) begin bad++; $display("FAIL lhu_stall: got %0d want 5", n_stall); end
    total++; if (n_req != 4) begin bad++; $display("FAIL lhu_req_cycles: got %0d want 4", n_req); end
    total++; if (held_ok !== 1'b1) begin bad++; $display("FAIL lhu_bus_hold: got %b want 1", held_ok); end
    total++; if (done_cyc != 6) begin bad++; $display("FAIL lhu_done_cycle: got %0d want 6", done_cyc); end
    total++; if (cap_rdata !== 64'h0000_0000_0000_BEEF) begin bad++;
      $display("FAIL lhu_rdata: got %h want 000000000000beef", cap_rdata); end
  endtask

  task automatic test_store_word();
    do_access(2'b00, 1'b1, 3'b010, 64'h3004, 64'h1234_5678, 0, 64'hFFFF_FFFF_FFFF_FFFF);
    total++; if (cap_we !== 1'b1) begin bad++; $display("FAIL sw_we: got %b want 1", cap_we); end
    total++; if (cap_be !== 8'hF0) begin bad++; $display("FAIL sw_be: got %h want f0", cap_be); end
    total++; if (cap_wdata !== 64'h1234_5678_0000_0000) begin bad++;
      $display("FAIL sw_wdata: got %h want 1234567800000000", cap_wdata); end
    total++; if (done_cyc != 3) begin bad++; $display("FAIL sw_done_cycle: got %0d want 3", done_cyc); end
    total++; if (cap_rdata !== 64'h0) begin bad++; $display("FAIL sw_rdata: got %h want 0", cap_rdata); end
  endtask

  task automatic test_store_wins();
    do_access(2'b01, 1'b1, 3'b011, 64'h3008, 64'hA5A5_5A5A_0F0F_F0F0, 0, 64'h1111_2222_3333_4444);
    total++; if (cap_we !== 1'b1 || cap_be !== 8'hFF) begin bad++;
      $display("FAIL store_wins_bus: got we=%b be=%h want we=1 be=ff", cap_we, cap_be); end
    total++; if (cap_wdata !== 64'hA5A5_5A5A_0F0F_F0F0) begin bad++;
      $display("FAIL store_wins_wdata: got %h want a5a55a5a0f0ff0f0", cap_wdata); end
    total++; if (cap_rdata !== 64'h0) begin bad++; $display("FAIL store_wins_rdata: got %h want 0", cap_rdata); end
  endtask

  task automatic test_load_word_signed();
    do_access(2'b01, 1'b0, 3'b010, 64'h6004, 64'h0, 1, 64'h8765_4321_0000_0000);
    total++; if (cap_rdata !== 64'hFFFF_FFFF_8765_4321) begin bad++;
      $display("FAIL lw_rdata: got %h want ffffffff87654321", cap_rdata); end
    total++; if (n_stall != 3 || done_cyc != 4) begin bad++;
      $display("FAIL lw_timing: got stall=%0d done=%0d want 3 4", n_stall, done_cyc); end
    total++; if (rdata !== 64'hFFFF_FFFF_8765_4321) begin bad++;
      $display("FAIL lw_rdata_hold: got %h want ffffffff87654321", rdata); end
  endtask

  task automatic test_mask_other_is_double();
    do_access(2'b01, 1'b0, 3'b111, 64'h5000, 64'h0, 0, 64'h0123_4567_89AB_CDEF);
    total++; if (cap_be !== 8'hFF) begin bad++; $display("FAIL mask7_be: got %h want ff", cap_be); end
    total++; if (cap_rdata !== 64'h0123_4567_89AB_CDEF) begin bad++;
      $display("FAIL mask7_rdata: got %h want 0123456789abcdef", cap_rdata); end
  endtask

  task automatic test_misaligned();
    do_access(2'b01, 1'b0, 3'b011, 64'h4004, 64'h0, 0, 64'hDEAD_BEEF_DEAD_BEEF);
    total++; if (saw_req !== 1'b0) begin bad++; $display("FAIL mis_d_bus: got req=%b want 0", saw_req); end
    total++; if (n_stall != 1 || done_cyc != 2) begin bad++;
      $display("FAIL mis_d_timing: got stall=%0d done=%0d want 1 2", n_stall, done_cyc); end
    total++; if (cap_fault !== 1'b1 || cap_rdata !== 64'h0) begin bad++;
      $display("FAIL mis_d_result: got fault=%b rdata=%h want 1 0", cap_fault, cap_rdata); end
    total++; if (fault !== 1'b1) begin bad++; $display("FAIL mis_fault_hold: got %b want 1", fault); end
    do_access(2'b01, 1'b0, 3'b001, 64'h4001, 64'h0, 0, 64'h0);
    total++; if (saw_req !== 1'b0 || cap_fault !== 1'b1) begin bad++;
      $display("FAIL mis_h: got req=%b fault=%b want 0 1", saw_req, cap_fault); end
    do_access(2'b00, 1'b1, 3'b010, 64'h4006, 64'h55, 0, 64'h0);
    total++; if (saw_req !== 1'b0 || cap_fault !== 1'b1) begin bad++;
      $display("FAIL mis_w_store: got req=%b fault=%b want 0 1", saw_req, cap_fault); end
    do_access(2'b01, 1'b0, 3'b000, 64'h4007, 64'h0, 0, 64'h7F00_0000_0000_0000);
    total++; if (cap_fault !== 1'b0 || cap_rdata !== 64'h7F) begin bad++;
      $display("FAIL byte_odd_ok: got fault=%b rdata=%h want 0 7f", cap_fault, cap_rdata); end
  endtask

  task automatic test_ack_outside_req();
    logic seen;
    seen = 1'b0;
    @(posedge clk); #1;
    bus_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done || stall || bus_req) seen = 1'b1;
    end
    bus_ack = 1'b0;
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL ack_idle: got activity=%b want 0", seen); end
  endtask

  task automatic test_reset_mid_req();
    int hi;
    hi = 0;
    @(posedge clk); #1;
    memRead = 2'b01; memMask = 3'b011; addr = 64'h8000; bus_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus_req) hi++;
    end
    total++; if (hi != 3) begin bad++; $display("FAIL rst_pre_req: got %0d want 3", hi); end
    #2 reset = 1'b0;
    #1;
    total++; if ({bus_req, stall, done} !== 3'b000) begin bad++;
      $display("FAIL rst_async: got req/stall/done=%b want 000", {bus_req, stall, done}); end
    clear_inputs();
    @(negedge clk);
    reset = 1'b1;
    do_access(2'b11, 1'b0, 3'b000, 64'h9001, 64'h0, 0, 64'h0000_0000_0000_F000);
    total++; if (n_stall != 2 || done_cyc != 3 || cap_rdata !== 64'hF0) begin bad++;
      $display("FAIL rst_recover: got stall=%0d done=%0d rdata=%h want 2 3 f0", n_stall, done_cyc, cap_rdata); end
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout();
    do_access(2'b01, 1'b0, 3'b011, 64'hA000, 64'h0, 1000, 64'h1);
    total++; if (n_req != 4 || done_cyc != 6) begin bad++;
      $display("FAIL timeout_len: got req=%0d done=%0d want 4 6", n_req, done_cyc); end
    total++; if (cap_fault !== 1'b1 || cap_rdata !== 64'h0) begin bad++;
      $display("FAIL timeout_result: got fault=%b rdata=%h want 1 0", cap_fault, cap_rdata); end
  endtask
`else
  task automatic test_timeout();
    int hi;
    hi = 0;
    @(posedge clk); #1;
    memRead = 2'b01; memMask = 3'b011; addr = 64'hA000; bus_ack = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (bus_req && stall && !done) hi++;
    end
    total++; if (hi != 120) begin bad++; $display("FAIL no_timeout: got %0d want 120", hi); end
    #2 reset = 1'b0;
    clear_inputs();
    @(negedge clk);
    reset = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_load_byte_signed();
    test_load_half_unsigned_wait();
    test_store_word();
    test_store_wins();
    test_load_word_signed();
    test_mask_other_is_double();
    test_misaligned();
    test_ack_outside_req();
    test_reset_mid_req();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
